// File: rtl/apc_pkg.sv
// Shared types and constants for the APC detection controller.
package apc_pkg;

  localparam int OUTPUT_WIDTH = 39;
  localparam int THRESH_FRAC  = 8;

  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    WARMUP   = 3'd1,
    SEARCH   = 3'd2,
    PLATEAU  = 3'd3,
    HOLDOFF  = 3'd4
  } apc_state_t;

endpackage

// File: rtl/apc_metric_cmp.sv
// Two-stage magnitude estimate and threshold compare of APC autocorrelation
// against scaled power. Each stage advances only on its own sample strobe.
module apc_metric_cmp
  import apc_pkg::*;
#(
  parameter int OUTPUT_WIDTH = apc_pkg::OUTPUT_WIDTH
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_clear,
  input  logic                           i_valid,
  input  logic signed [OUTPUT_WIDTH-1:0] i_acorr_re,
  input  logic signed [OUTPUT_WIDTH-1:0] i_acorr_im,
  input  logic        [OUTPUT_WIDTH-1:0] i_power,
  input  logic        [THRESH_FRAC-1:0]  i_thresh,
  input  logic        [OUTPUT_WIDTH-1:0] i_min_power,
  output logic                           o_above,
  output logic                           o_strobe
);

  localparam int PW = OUTPUT_WIDTH + THRESH_FRAC + 1;

  logic [OUTPUT_WIDTH-1:0] abs_re, abs_im, mag_max, mag_min;
  logic [OUTPUT_WIDTH:0]   mag_next;
  logic [OUTPUT_WIDTH:0]   s1_mag;
  logic [OUTPUT_WIDTH-1:0] s1_power;
  logic                    s1_pwr_ok;
  logic                    s1_valid;
  logic [PW-1:0]           lhs, rhs;

  // Magnitude approximation max + min/2; the unsigned abs keeps 2^(W-1) intact.
  always_comb begin
    abs_re   = i_acorr_re[OUTPUT_WIDTH-1] ? -i_acorr_re : i_acorr_re;
    abs_im   = i_acorr_im[OUTPUT_WIDTH-1] ? -i_acorr_im : i_acorr_im;
    mag_max  = (abs_re >= abs_im) ? abs_re : abs_im;
    mag_min  = (abs_re >= abs_im) ? abs_im : abs_re;
    mag_next = {1'b0, mag_max} + {1'b0, mag_min >> 1};
  end

  // Exact unsigned compare of mag*2^THRESH_FRAC against thresh*power.
  always_comb begin
    lhs = {s1_mag, {THRESH_FRAC{1'b0}}};
    rhs = PW'(i_thresh) * PW'(s1_power);
  end

  // Pipeline registers: stage 1 on i_valid, stage 2 on the delayed strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid  <= 1'b0;
      s1_mag    <= '0;
      s1_power  <= '0;
      s1_pwr_ok <= 1'b0;
      o_strobe  <= 1'b0;
      o_above   <= 1'b0;
    end else if (i_clear) begin
      s1_valid  <= 1'b0;
      s1_mag    <= '0;
      s1_power  <= '0;
      s1_pwr_ok <= 1'b0;
      o_strobe  <= 1'b0;
      o_above   <= 1'b0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_mag    <= mag_next;
        s1_power  <= i_power;
        s1_pwr_ok <= (i_power >= i_min_power);
      end
      o_strobe <= s1_valid;
      if (s1_valid) begin
        o_above <= (lhs >= rhs) && s1_pwr_ok;
      end
    end
  end

endmodule

// File: rtl/apc_detect_ctrl.sv
// APC detection sequencer: warm-up, plateau search, detect pulse and hold-off,
// with APC window flush on enable and after every detect.
module apc_detect_ctrl
  import apc_pkg::*;
#(
  parameter int          OUTPUT_WIDTH   = apc_pkg::OUTPUT_WIDTH,
  parameter int unsigned WARMUP_SAMPLES = 200,
  parameter int          CNT_WIDTH      = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_enable,
  input  logic        [7:0]              i_thresh,
  input  logic        [OUTPUT_WIDTH-1:0] i_min_power,
  input  logic        [CNT_WIDTH-1:0]    i_min_run,
  input  logic        [CNT_WIDTH-1:0]    i_holdoff,
  input  logic signed [OUTPUT_WIDTH-1:0] i_acorr_re,
  input  logic signed [OUTPUT_WIDTH-1:0] i_acorr_im,
  input  logic        [OUTPUT_WIDTH-1:0] i_power,
  input  logic                           i_valid,
  output logic                           o_apc_flush,
  output logic                           o_detect,
  output logic        [CNT_WIDTH-1:0]    o_run_len,
  output logic        [2:0]              o_state
);

  localparam int                   CW1       = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CW1-1:0]       CW1_ONE   = CW1'(1);
  localparam logic [CW1-1:0]       WARM_LAST = CW1'(WARMUP_SAMPLES);

  apc_state_t           state, state_d;
  logic [CNT_WIDTH-1:0] run_q, run_d, hold_q, hold_d, warm_q, warm_d;
  logic [CNT_WIDTH-1:0] run_len_d, min_run_eff;
  logic [CW1-1:0]       warm_inc, hold_inc;
  logic                 detect_d, flush_d;
  logic                 flag_above, flag_strobe;
  logic                 metric_clear;

  assign metric_clear = ~i_enable;
  assign o_state      = state;

  apc_metric_cmp #(
    .OUTPUT_WIDTH(OUTPUT_WIDTH)
  ) u_metric (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (metric_clear),
    .i_valid     (i_valid),
    .i_acorr_re  (i_acorr_re),
    .i_acorr_im  (i_acorr_im),
    .i_power     (i_power),
    .i_thresh    (i_thresh),
    .i_min_power (i_min_power),
    .o_above     (flag_above),
    .o_strobe    (flag_strobe)
  );

  // Next-state, counter and output decode; disable overrides everything.
  always_comb begin
    state_d     = state;
    run_d       = run_q;
    hold_d      = hold_q;
    warm_d      = warm_q;
    run_len_d   = o_run_len;
    detect_d    = 1'b0;
    flush_d     = 1'b0;
    min_run_eff = (i_min_run == '0) ? CNT_ONE : i_min_run;
    warm_inc    = {1'b0, warm_q} + CW1_ONE;
    hold_inc    = {1'b0, hold_q} + CW1_ONE;

    if (!i_enable) begin
      state_d = DISABLED;
      run_d   = '0;
      hold_d  = '0;
      warm_d  = '0;
    end else begin
      case (state)
        DISABLED: begin
          flush_d = 1'b1;
          warm_d  = '0;
          state_d = WARMUP;
        end
        WARMUP: begin
          if (flag_strobe) begin
            warm_d = warm_inc[CNT_WIDTH-1:0];
            if (warm_inc >= WARM_LAST) state_d = SEARCH;
          end
        end
        SEARCH: begin
          if (flag_strobe && flag_above) begin
            run_d   = CNT_ONE;
            state_d = PLATEAU;
          end
        end
        PLATEAU: begin
          if (flag_strobe) begin
            if (flag_above) begin
              if (run_q != '1) run_d = run_q + CNT_ONE;
            end else if (run_q >= min_run_eff) begin
              detect_d  = 1'b1;
              flush_d   = 1'b1;
              run_len_d = run_q;
              hold_d    = '0;
              state_d   = HOLDOFF;
            end else begin
              state_d = SEARCH;
            end
          end
        end
        HOLDOFF: begin
          if (flag_strobe) begin
            hold_d = hold_inc[CNT_WIDTH-1:0];
            if (hold_inc >= {1'b0, i_holdoff}) begin
              warm_d  = '0;
              state_d = WARMUP;
            end
          end
        end
        default: state_d = DISABLED;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= DISABLED;
      run_q       <= '0;
      hold_q      <= '0;
      warm_q      <= '0;
      o_run_len   <= '0;
      o_detect    <= 1'b0;
      o_apc_flush <= 1'b0;
    end else begin
      state       <= state_d;
      run_q       <= run_d;
      hold_q      <= hold_d;
      warm_q      <= warm_d;
      o_run_len   <= run_len_d;
      o_detect    <= detect_d;
      o_apc_flush <= flush_d;
    end
  end

endmodule
